// File: rtl/fd_bank_arbiter.sv
// Two-requester round-robin arbiter/sequencer for a DEPTH x WIDTH flop bank with word write, preset, clear and read.
// Latency: req sampled high -> gnt after 1 edge, ack after 2 edges; release takes one edge after req drops.
// Backpressure: 4-phase req/ack; gnt/ack hold until the winner drops req, and the loser waits with req high.
module fd_bank_arbiter #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic                   CP,
  input  logic                   CD,
  input  logic                   req0,
  input  logic [1:0]             op0,
  input  logic [AW-1:0]          addr0,
  input  logic [WIDTH-1:0]       wdata0,
  input  logic                   req1,
  input  logic [1:0]             op1,
  input  logic [AW-1:0]          addr1,
  input  logic [WIDTH-1:0]       wdata1,
  output logic                   gnt0,
  output logic                   gnt1,
  output logic                   ack0,
  output logic                   ack1,
  output logic [WIDTH-1:0]       rdata,
  output logic [DEPTH*WIDTH-1:0] q_flat
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [1:0] OP_WRITE  = 2'b00;
  localparam logic [1:0] OP_PRESET = 2'b01;
  localparam logic [1:0] OP_CLEAR  = 2'b10;
  localparam logic [1:0] OP_READ   = 2'b11;

  logic [1:0]       state_q, state_d;
  logic             gnt0_q, gnt0_d;
  logic             gnt1_q, gnt1_d;
  logic             ack0_q, ack0_d;
  logic             ack1_q, ack1_d;
  logic             rr_q, rr_d;       // 0: requester 0 wins a tie, 1: requester 1 wins
  logic [1:0]       op_q, op_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic [WIDTH-1:0] wdata_q, wdata_d;
  logic [WIDTH-1:0] rdata_q, rdata_d;

  logic [WIDTH-1:0] bank_q [DEPTH];
  logic             bank_we;
  logic [WIDTH-1:0] bank_wdat;
  logic             pick1;
  logic             winner_req;

  // Next-state logic: arbitration in IDLE, bank access in EXEC, handshake release in DONE
  always_comb begin
    state_d   = state_q;
    gnt0_d    = gnt0_q;
    gnt1_d    = gnt1_q;
    ack0_d    = ack0_q;
    ack1_d    = ack1_q;
    rr_d      = rr_q;
    op_d      = op_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    bank_we   = 1'b0;
    bank_wdat = '0;
    // Requester 1 wins when it is the only one asking, or on a tie when the pointer favours it
    pick1      = req1 & (~req0 | rr_q);
    winner_req = gnt1_q ? req1 : req0;

    case (state_q)
      ST_IDLE: begin
        if (req0 || req1) begin
          if (pick1) begin
            gnt1_d  = 1'b1;
            op_d    = op1;
            addr_d  = addr1;
            wdata_d = wdata1;
          end else begin
            gnt0_d  = 1'b1;
            op_d    = op0;
            addr_d  = addr0;
            wdata_d = wdata0;
          end
          state_d = ST_EXEC;
        end
      end

      ST_EXEC: begin
        case (op_q)
          OP_WRITE: begin
            bank_we   = 1'b1;
            bank_wdat = wdata_q;
          end
          OP_PRESET: begin
            bank_we   = 1'b1;
            bank_wdat = '1;
          end
          OP_CLEAR: begin
            bank_we   = 1'b1;
            bank_wdat = '0;
          end
          OP_READ: begin
            rdata_d = bank_q[addr_q];
          end
          default: begin
            bank_we = 1'b0;
          end
        endcase
        // Only the granted side can be acknowledged
        ack0_d  = gnt0_q;
        ack1_d  = gnt1_q;
        state_d = ST_DONE;
      end

      ST_DONE: begin
        if (!winner_req) begin
          gnt0_d  = 1'b0;
          gnt1_d  = 1'b0;
          ack0_d  = 1'b0;
          ack1_d  = 1'b0;
          // Hand priority to whoever did not just finish
          rr_d    = gnt0_q;
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
        gnt0_d  = 1'b0;
        gnt1_d  = 1'b0;
        ack0_d  = 1'b0;
        ack1_d  = 1'b0;
      end
    endcase
  end

  // Control and handshake registers; reset aborts any in-flight access
  always_ff @(posedge CP or negedge CD) begin
    if (!CD) begin
      state_q <= ST_IDLE;
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
      rr_q    <= 1'b0;
      op_q    <= OP_WRITE;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      gnt0_q  <= gnt0_d;
      gnt1_q  <= gnt1_d;
      ack0_q  <= ack0_d;
      ack1_q  <= ack1_d;
      rr_q    <= rr_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  // Register bank: cleared by reset, one word updated per EXEC cycle at most
  always_ff @(posedge CP or negedge CD) begin
    if (!CD) begin
      for (int i = 0; i < DEPTH; i++) begin
        bank_q[i] <= '0;
      end
    end else if (bank_we) begin
      bank_q[addr_q] <= bank_wdat;
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_flat
    assign q_flat[g*WIDTH +: WIDTH] = bank_q[g];
  end

  assign gnt0  = gnt0_q;
  assign gnt1  = gnt1_q;
  assign ack0  = ack0_q;
  assign ack1  = ack1_q;
  assign rdata = rdata_q;

endmodule

// File: tb/tb_fd_bank_arbiter.sv
// Bench for fd_bank_arbiter: transaction-level model checked every cycle, plus directed literal checks.
// Inputs are driven 1 time unit after the rising edge; outputs are compared on the falling edge.
// Requesters follow the 4-phase protocol; every wait is bounded.
module tb_fd_bank_arbiter;
  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int AW    = 2;
  localparam logic [1:0] OP_W = 2'b00;
  localparam logic [1:0] OP_P = 2'b01;
  localparam logic [1:0] OP_C = 2'b10;
  localparam logic [1:0] OP_R = 2'b11;

  logic CP = 1'b0;
  logic CD = 1'b1;
  logic req0 = 1'b0, req1 = 1'b0;
  logic [1:0] op0 = '0, op1 = '0;
  logic [AW-1:0] addr0 = '0, addr1 = '0;
  logic [WIDTH-1:0] wdata0 = '0, wdata1 = '0;
  logic gnt0, gnt1, ack0, ack1;
  logic [WIDTH-1:0] rdata;
  logic [DEPTH*WIDTH-1:0] q_flat;

  int ncheck = 0;
  int nfail  = 0;
  bit cmp_en = 1'b0;

  // Transaction-level model: who owns the bank and how many edges since the grant
  int m_owner = -1;
  int m_age   = 0;
  bit m_rr    = 1'b0;
  logic [1:0]       m_op = '0;
  logic [AW-1:0]    m_addr = '0;
  logic [WIDTH-1:0] m_wdata = '0;
  logic [WIDTH-1:0] m_rdata = '0;
  logic [WIDTH-1:0] m_bank [DEPTH];
  int order_q[$];

  fd_bank_arbiter #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) dut (
    .CP(CP), .CD(CD),
    .req0(req0), .op0(op0), .addr0(addr0), .wdata0(wdata0),
    .req1(req1), .op1(op1), .addr1(addr1), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .ack0(ack0), .ack1(ack1),
    .rdata(rdata), .q_flat(q_flat)
  );

  always #5 CP = ~CP;

  initial begin
    #1000000;
    $display("FAIL watchdog expired act=running exp=finished");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    ncheck++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s act=%0h exp=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int pick(bit r0, bit r1, bit rr);
    if (r0 && r1) return rr ? 1 : 0;
    return r1 ? 1 : 0;
  endfunction

  function automatic logic [DEPTH*WIDTH-1:0] exp_flat();
    logic [DEPTH*WIDTH-1:0] e;
    e = '0;
    for (int i = 0; i < DEPTH; i++) e[i*WIDTH +: WIDTH] = m_bank[i];
    return e;
  endfunction

  // Reference model: grant on an idle edge, act on the following edge, release when the owner drops req
  always @(posedge CP or negedge CD) begin
    if (!CD) begin
      m_owner <= -1;
      m_age   <= 0;
      m_rr    <= 1'b0;
      m_rdata <= '0;
      for (int i = 0; i < DEPTH; i++) m_bank[i] <= '0;
    end else if (m_owner < 0) begin
      if (req0 || req1) begin
        if (pick(req0, req1, m_rr) == 1) begin
          m_owner <= 1; m_op <= op1; m_addr <= addr1; m_wdata <= wdata1;
        end else begin
          m_owner <= 0; m_op <= op0; m_addr <= addr0; m_wdata <= wdata0;
        end
        m_age <= 1;
      end
    end else if (m_age == 1) begin
      case (m_op)
        OP_W:    m_bank[m_addr] <= m_wdata;
        OP_P:    m_bank[m_addr] <= '1;
        OP_C:    m_bank[m_addr] <= '0;
        default: m_rdata <= m_bank[m_addr];
      endcase
      m_age <= 2;
    end else if (!((m_owner == 1) ? req1 : req0)) begin
      m_rr    <= (m_owner == 0);
      m_owner <= -1;
      m_age   <= 0;
    end
  end

  // Per-cycle comparison against the model
  always @(negedge CP) begin
    if (cmp_en) begin
      chk("gnt0", gnt0, m_owner == 0);
      chk("gnt1", gnt1, m_owner == 1);
      chk("ack0", ack0, (m_owner == 0) && (m_age >= 2));
      chk("ack1", ack1, (m_owner == 1) && (m_age >= 2));
      chk("rdata", rdata, m_rdata);
      chk("q_flat", q_flat, exp_flat());
      chk("gnt_excl", gnt0 & gnt1, 1'b0);
    end
  end

  task automatic set_req(input int r, input logic v);
    if (r == 0) req0 = v; else req1 = v;
  endtask

  task automatic set_cmd(input int r, input logic [1:0] op, input logic [AW-1:0] a, input logic [WIDTH-1:0] d);
    if (r == 0) begin op0 = op; addr0 = a; wdata0 = d; end
    else        begin op1 = op; addr1 = a; wdata1 = d; end
  endtask

  task automatic scramble(input int r);
    set_cmd(r, 2'($urandom_range(0, 3)), AW'($urandom_range(0, DEPTH-1)), WIDTH'($urandom));
  endtask

  function automatic logic get_ack(input int r);
    return (r == 0) ? ack0 : ack1;
  endfunction

  function automatic logic get_gnt(input int r);
    return (r == 0) ? gnt0 : gnt1;
  endfunction

  // One 4-phase transaction; call 1 unit after a rising edge
  task automatic do_txn(input int r, input logic [1:0] op, input logic [AW-1:0] a,
                        input logic [WIDTH-1:0] d, input int hold, input bit scr,
                        output int lat, output time t_ack, output time t_drop);
    bit ok;
    set_cmd(r, op, a, d);
    set_req(r, 1'b1);
    lat = 0;
    ok = 1'b0;
    t_ack = 0;
    for (int n = 0; n < 100; n++) begin
      @(posedge CP); #1;
      lat++;
      if (get_ack(r)) begin ok = 1'b1; break; end
      if (scr) scramble(r);
    end
    if (!ok) begin
      ncheck++; nfail++;
      $display("FAIL ack_timeout req%0d act=no_ack exp=ack", r);
    end else begin
      t_ack = $time;
      order_q.push_back(r);
      for (int h = 0; h < hold; h++) begin
        if (scr) scramble(r);
        @(posedge CP); #1;
        chk("hold_gnt_ack", {get_gnt(r), get_ack(r)}, 2'b11);
      end
    end
    set_req(r, 1'b0);
    t_drop = $time;
    ok = 1'b0;
    for (int n = 0; n < 100; n++) begin
      @(posedge CP); #1;
      if (!get_gnt(r)) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      ncheck++; nfail++;
      $display("FAIL release_timeout req%0d act=gnt_high exp=gnt_low", r);
    end
  endtask

  task automatic rand_master(input int r, input int n);
    int  lat;
    time ta, td;
    for (int k = 0; k < n; k++) begin
      for (int g = 0; g < int'($urandom_range(0, 3)); g++) begin
        scramble(r);
        @(posedge CP); #1;
      end
      do_txn(r, 2'($urandom_range(0, 3)), AW'($urandom_range(0, DEPTH-1)), WIDTH'($urandom),
             int'($urandom_range(0, 3)), 1'b1, lat, ta, td);
    end
  endtask

  initial begin
    int  lat;
    time ta, td;
    time ta0, td0, ta1, td1;
    int  la0, la1;
    logic [DEPTH*WIDTH-1:0] snap;

    // Reset with random inputs
    #3 CD = 1'b0;
    #1 cmp_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge CP); #1;
      req0 = 1'($urandom); req1 = 1'($urandom);
      scramble(0); scramble(1);
    end
    @(negedge CP);
    chk("rst_gnt", {gnt0, gnt1, ack0, ack1}, 4'b0);
    chk("rst_rdata", rdata, 8'h00);
    chk("rst_qflat", q_flat, 32'h0);
    @(posedge CP); #1;
    req0 = 1'b0; req1 = 1'b0;
    CD = 1'b1;
    repeat (3) @(posedge CP);
    @(negedge CP);
    chk("idle_outs", {gnt0, gnt1, ack0, ack1}, 4'b0);
    chk("idle_qflat", q_flat, 32'h0);

    // Single write then read
    @(posedge CP); #1;
    do_txn(0, OP_W, 2'd2, 8'hA5, 0, 1'b0, lat, ta, td);
    chk("wr_latency", lat, 2);
    snap = q_flat;
    chk("wr_word2", snap[23:16], 8'hA5);
    do_txn(0, OP_R, 2'd2, 8'h00, 0, 1'b0, lat, ta, td);
    chk("rd_latency", lat, 2);
    chk("rd_rdata", rdata, 8'hA5);

    // Preset then clear word 1
    do_txn(1, OP_P, 2'd1, 8'h00, 0, 1'b0, lat, ta, td);
    chk("preset_qflat", q_flat, 32'h00A5FF00);
    do_txn(1, OP_C, 2'd1, 8'h5A, 0, 1'b0, lat, ta, td);
    chk("clear_qflat", q_flat, 32'h00A50000);
    chk("clear_rdata_kept", rdata, 8'hA5);

    // Contention twice, then 8 back-to-back contested transactions
    for (int rep = 0; rep < 2; rep++) begin
      order_q.delete();
      fork
        begin int l; time a, b; do_txn(0, OP_W, 2'd0, 8'h11, 0, 1'b0, l, a, b); end
        begin int l; time a, b; do_txn(1, OP_W, 2'd3, 8'h22, 0, 1'b0, l, a, b); end
      join
      chk("contend_n", order_q.size(), 2);
      if (order_q.size() == 2) begin
        chk("contend_first", order_q[0], 0);
        chk("contend_second", order_q[1], 1);
      end
    end
    order_q.delete();
    fork
      begin int l; time a, b; for (int k = 0; k < 4; k++) do_txn(0, OP_R, 2'(k), 8'h00, 0, 1'b0, l, a, b); end
      begin int l; time a, b; for (int k = 0; k < 4; k++) do_txn(1, OP_W, 2'(k), 8'(k*16+3), 0, 1'b0, l, a, b); end
    join
    chk("alt_n", order_q.size(), 8);
    for (int k = 0; k < order_q.size(); k++) chk("alt_order", order_q[k], k % 2);

    // Handshake hold: requester 0 keeps req 5 cycles after ack; requester 1 waits
    fork
      do_txn(0, OP_W, 2'd0, 8'h77, 5, 1'b0, la0, ta0, td0);
      begin
        bit seen;
        seen = 1'b0;
        for (int n = 0; n < 100; n++) begin
          @(posedge CP); #1;
          if (ack0) begin seen = 1'b1; break; end
        end
        chk("hold_saw_ack0", seen, 1'b1);
        do_txn(1, OP_R, 2'd0, 8'h00, 0, 1'b0, la1, ta1, td1);
      end
    join
    chk("hold_order", ta1 > td0, 1'b1);
    chk("hold_rdata", rdata, 8'h77);

    // Leave the pointer favouring requester 1, then reset during EXEC
    do_txn(0, OP_W, 2'd1, 8'h99, 0, 1'b0, lat, ta, td);
    set_cmd(0, OP_W, 2'd2, 8'h3C);
    req0 = 1'b1;
    @(posedge CP); #1;
    chk("midop_granted", gnt0, 1'b1);
    CD = 1'b0;
    #1;
    chk("midop_gnt_ack", {gnt0, gnt1, ack0, ack1}, 4'b0);
    req0 = 1'b0;
    repeat (2) @(posedge CP);
    #1;
    snap = q_flat;
    chk("midop_word2", snap[23:16], 8'h00);
    CD = 1'b1;
    @(posedge CP); #1;
    order_q.delete();
    fork
      begin int l; time a, b; do_txn(1, OP_W, 2'd3, 8'h44, 0, 1'b0, l, a, b); end
      begin int l; time a, b; do_txn(0, OP_W, 2'd0, 8'h33, 0, 1'b0, l, a, b); end
    join
    chk("post_rst_n", order_q.size(), 2);
    if (order_q.size() == 2) chk("post_rst_first", order_q[0], 0);

    // Randomized traffic from both masters
    fork
      rand_master(0, 60);
      rand_master(1, 60);
    join
    repeat (3) @(posedge CP);
    @(negedge CP);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", ncheck, nfail);
    $finish;
  end

endmodule
